// File: rtl/iiitb_counter_pkg.sv
// Shared BCD constants and elaboration helpers
// for the N-digit BCD counter.
package iiitb_counter_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    function automatic logic [31:0] int_to_bcd(input int value, input int digits);
        logic [31:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            if (i < digits) begin
                r[i*BCD_W +: BCD_W] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [31:0] vec, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < digits && vec[i*BCD_W +: BCD_W] > BCD_NINE)
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/iiitb_bcd_digit.sv
// One BCD decade: clear, load, or step up/down
// when enabled by the lower digits.
module iiitb_bcd_digit
    import iiitb_counter_pkg::*;
(
    input  logic             ck,
    input  logic             rn,
    input  logic             ci,
    input  logic             up,
    input  logic             load,
    input  logic             clr,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             at_nine,
    output logic             at_zero
);

    assign at_nine = (q == BCD_NINE);
    assign at_zero = (q == '0);

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (ci) begin
            if (up)
                q <= at_nine ? '0 : q + 4'd1;
            else
                q <= at_zero ? BCD_NINE : q - 4'd1;
        end
    end

endmodule

// File: rtl/iiitb_bcd_counter_n.sv
// N-digit up/down BCD counter with clear, checked load,
// terminal-count flag and registered wrap/load-error pulses.
module iiitb_bcd_counter_n
    import iiitb_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int LIMIT  = 99
)
(
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  CLR,
    input  logic                  LD,
    input  logic [BCD_W*DIGITS-1:0] D,
    output logic [BCD_W*DIGITS-1:0] Q,
    output logic                  TC,
    output logic                  WRAP,
    output logic                  LD_ERR
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [31:0]  LIMIT_FULL = int_to_bcd(LIMIT, DIGITS);
    localparam logic [W-1:0] LIMIT_BCD  = LIMIT_FULL[W-1:0];

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("iiitb_bcd_counter_n: DIGITS out of range 1..8");
        end
        else if (LIMIT < 1 || LIMIT > 10**DIGITS - 1) begin : g_bad_limit
            $error("iiitb_bcd_counter_n: LIMIT out of range");
        end
    endgenerate

    logic [DIGITS-1:0] at_nine;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS:0]   chain;
    logic [31:0]       d_ext;
    logic              ld_ok;
    logic              term;
    logic              step;
    logic              wrap_now;
    logic              dig_load;
    logic [W-1:0]      dig_d;

    always_comb begin
        d_ext = '0;
        d_ext[W-1:0] = D;
    end

    // BCD ordering matches binary ordering once every nibble is <= 9
    assign ld_ok = bcd_valid(d_ext, DIGITS) && (D <= LIMIT_BCD);

    // chain[DIGITS] in the down direction is exactly "Q == 0"
    always_comb begin
        chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            chain[i+1] = chain[i] & (UP ? at_nine[i] : at_zero[i]);
    end

    assign term     = UP ? (Q == LIMIT_BCD) : chain[DIGITS];
    assign TC       = EN & term;
    assign step     = EN & ~CLR & ~LD;
    assign wrap_now = step & term;
    assign dig_load = (LD & ld_ok) | wrap_now;
    assign dig_d    = wrap_now ? (UP ? '0 : LIMIT_BCD) : D;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            iiitb_bcd_digit u_dig (
                .ck      (CK),
                .rn      (RN),
                .ci      (step & chain[g]),
                .up      (UP),
                .load    (dig_load),
                .clr     (CLR),
                .d       (dig_d[g*BCD_W +: BCD_W]),
                .q       (Q[g*BCD_W +: BCD_W]),
                .at_nine (at_nine[g]),
                .at_zero (at_zero[g])
            );
        end
    endgenerate

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            WRAP   <= 1'b0;
            LD_ERR <= 1'b0;
        end else begin
            WRAP   <= wrap_now;
            LD_ERR <= ~CLR & LD & ~ld_ok;
        end
    end

endmodule

// File: tb/tb_iiitb_bcd_counter_n.sv
// Directed bench for iiitb_bcd_counter_n across three
// parameter sets (2/99, 2/59, 3/999).
module tb_iiitb_bcd_counter_n;

    logic CK = 1'b0;
    logic rn;
    int total = 0;
    int bad = 0;

    always #5 CK = ~CK;

    logic a_en, a_up, a_clr, a_ld, a_tc, a_wrap, a_err;
    logic [7:0] a_d, a_q;
    logic b_en, b_up, b_clr, b_ld, b_tc, b_wrap, b_err;
    logic [7:0] b_d, b_q;
    logic c_en, c_up, c_clr, c_ld, c_tc, c_wrap, c_err;
    logic [11:0] c_d, c_q;

    iiitb_bcd_counter_n #(.DIGITS(2), .LIMIT(99)) u_a (
        .CK(CK), .RN(rn), .EN(a_en), .UP(a_up), .CLR(a_clr), .LD(a_ld),
        .D(a_d), .Q(a_q), .TC(a_tc), .WRAP(a_wrap), .LD_ERR(a_err));

    iiitb_bcd_counter_n #(.DIGITS(2), .LIMIT(59)) u_b (
        .CK(CK), .RN(rn), .EN(b_en), .UP(b_up), .CLR(b_clr), .LD(b_ld),
        .D(b_d), .Q(b_q), .TC(b_tc), .WRAP(b_wrap), .LD_ERR(b_err));

    iiitb_bcd_counter_n #(.DIGITS(3), .LIMIT(999)) u_c (
        .CK(CK), .RN(rn), .EN(c_en), .UP(c_up), .CLR(c_clr), .LD(c_ld),
        .D(c_d), .Q(c_q), .TC(c_tc), .WRAP(c_wrap), .LD_ERR(c_err));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    function automatic int bcd2int(input logic [31:0] v, input int n);
        int r;
        r = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (v[i*4 +: 4] > 4'd9) return -1;
            r = r * 10 + int'(v[i*4 +: 4]);
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(negedge CK) begin
        check("inv_a", ((bcd2int(32'(a_q), 2) >= 0) && (bcd2int(32'(a_q), 2) <= 99)), 1);
        check("inv_b", ((bcd2int(32'(b_q), 2) >= 0) && (bcd2int(32'(b_q), 2) <= 59)), 1);
        check("inv_c", ((bcd2int(32'(c_q), 3) >= 0) && (bcd2int(32'(c_q), 3) <= 999)), 1);
    end

    initial begin
        rn = 1'b0;
        {a_en, a_up, a_clr, a_ld} = 4'b0100; a_d = '0;
        {b_en, b_up, b_clr, b_ld} = 4'b0000; b_d = '0;
        {c_en, c_up, c_clr, c_ld} = 4'b0100; c_d = '0;
        #12;
        check("rst_q", a_q, 0);
        check("rst_wrap", a_wrap, 0);
        check("rst_err", a_err, 0);
        rn = 1'b1;

        // A: full up sweep 00..99 -> 00
        a_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            check("a_tc", a_tc, (k == 100));
            tick();
            check("a_up_q", a_q, bcd2(k % 100));
            check("a_up_wrap", a_wrap, (k == 100));
        end

        // A: loads
        a_en = 1'b0; a_ld = 1'b1; a_d = 8'h37;
        tick();
        check("ld37_q", a_q, 8'h37);
        check("ld37_err", a_err, 0);
        a_d = 8'h3A;
        tick();
        check("ld3A_q", a_q, 8'h37);
        check("ld3A_err", a_err, 1);
        a_ld = 1'b0;
        tick();
        check("err_pulse", a_err, 0);

        // A: clear beats load and count, load beats count
        a_ld = 1'b1; a_d = 8'h42;
        tick();
        check("ld42", a_q, 8'h42);
        a_clr = 1'b1; a_en = 1'b1; a_d = 8'h15;
        tick();
        check("clr_q", a_q, 8'h00);
        check("clr_err", a_err, 0);
        a_clr = 1'b0;
        tick();
        check("ld15_noinc", a_q, 8'h15);
        a_ld = 1'b0;
        tick();
        check("inc16", a_q, 8'h16);

        // A: direction flip at 99 gives no wrap
        a_en = 1'b0; a_ld = 1'b1; a_d = 8'h99;
        tick();
        a_ld = 1'b0; a_en = 1'b1; a_up = 1'b1;
        #1 check("tc99", a_tc, 1);
        a_up = 1'b0;
        #1 check("tc99_dn", a_tc, 0);
        tick();
        check("flip_q", a_q, 8'h98);
        check("flip_wrap", a_wrap, 0);

        // A: asynchronous reset mid-cycle
        a_en = 1'b0; a_ld = 1'b1; a_d = 8'h73;
        tick();
        a_d = 8'hAA;
        tick();
        check("pre_rst_q", a_q, 8'h73);
        check("pre_rst_err", a_err, 1);
        a_ld = 1'b0; a_en = 1'b1; a_up = 1'b0;
        #1 rn = 1'b0;
        #1;
        check("arst_q", a_q, 8'h00);
        check("arst_err", a_err, 0);
        check("arst_wrap", a_wrap, 0);
        check("arst_tc", a_tc, 1);
        a_up = 1'b1;
        #1 rn = 1'b1;
        tick();
        check("post_rst", a_q, 8'h01);

        // B: LIMIT=59 down count from zero
        a_en = 1'b0;
        b_en = 1'b1; b_up = 1'b0;
        #1 check("b_tc0", b_tc, 1);
        tick();
        check("b_first", b_q, 8'h59);
        check("b_first_wrap", b_wrap, 1);
        for (int k = 58; k >= 0; k--) begin
            check("b_tc", b_tc, 0);
            tick();
            check("b_dn_q", b_q, bcd2(k));
            check("b_dn_wrap", b_wrap, 0);
        end
        check("b_tc00", b_tc, 1);
        tick();
        check("b_rewrap_q", b_q, 8'h59);
        check("b_rewrap", b_wrap, 1);
        b_en = 1'b0; b_ld = 1'b1; b_d = 8'h60;
        tick();
        check("b_ld60_q", b_q, 8'h59);
        check("b_ld60_err", b_err, 1);
        b_d = 8'h25;
        tick();
        check("b_ld25_q", b_q, 8'h25);
        check("b_ld25_err", b_err, 0);
        b_ld = 1'b0;

        // C: three-digit carry and borrow
        c_ld = 1'b1; c_d = 12'h099;
        tick();
        c_ld = 1'b0; c_en = 1'b1; c_up = 1'b1;
        tick();
        check("c_up100", c_q, 12'h100);
        c_up = 1'b0;
        tick();
        check("c_dn099", c_q, 12'h099);
        c_en = 1'b0;
        repeat (5) tick();
        check("c_hold", c_q, 12'h099);
        c_ld = 1'b1; c_d = 12'h999;
        tick();
        c_ld = 1'b0; c_en = 1'b1; c_up = 1'b1;
        tick();
        check("c_wrap_q", c_q, 12'h000);
        check("c_wrap", c_wrap, 1);
        tick();
        check("c_wrap_pulse", c_wrap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
